mul_div_unit: RTL and testbench
===============================

// Module: mul_div_unit
//
// PURPOSE
// Iterative RV32M multiply/divide unit; multi-cycle companion to the single-cycle ALU in the execute stage.
// Accepts one operation per handshake and computes one bit per clock (shift-add / restoring division).
// Returns a DATA_WIDTH result over a valid/ready output handshake.
// The pipeline stalls the execute stage while in_ready is low; flush kills an in-flight operation.
//
// PARAMETERS
// DATA_WIDTH     32  operand/result width; even, >= 8
// OPCODE_LENGTH  3   Operation width (RV32M funct3)
//
// PORTS
// clk        in   1              rising-edge clock
// rst_n      in   1              asynchronous, active-low reset
// flush      in   1              synchronous kill of the current operation
// in_valid   in   1              operands/Operation valid
// in_ready   out  1              unit can accept an operation
// SrcA       in   DATA_WIDTH     rs1 operand (dividend / multiplicand)
// SrcB       in   DATA_WIDTH     rs2 operand (divisor / multiplier)
// Operation  in   OPCODE_LENGTH  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
// out_valid  out  1              Result valid
// out_ready  in   1              consumer takes Result
// Result     out  DATA_WIDTH     MUL: low W bits; MULH*: high W bits of the 2W product; DIV*: quotient; REM*: remainder
//
// BEHAVIOUR
// - Reset (rst_n=0, any time, asynchronous): state=IDLE, in_ready=1, out_valid=0, Result=0, all internal regs=0.
// - States:
//   - IDLE -> CALC on accept (in_valid & in_ready).
//   - IDLE -> DONE on accept of a special case.
//   - CALC -> DONE after exactly DATA_WIDTH iteration edges.
//   - DONE -> IDLE on out_valid & out_ready.
// - in_ready = (state==IDLE) & ~flush. No overlap: a new operation is accepted only in IDLE.
// - Operands and Operation are captured on the accept edge; later input changes are ignored.
// - Latency, with E0 as the accept edge:
//   - Normal operation: out_valid rises after edge E0+DATA_WIDTH, i.e. accept-to-valid = DATA_WIDTH cycles.
//   - Special case: out_valid rises after E0 (1 cycle).
// - Signed handling: operands are converted to magnitudes on accept.
//   - Signedness: MULH, DIV and REM treat both operands as signed; MULHSU treats SrcA as signed and SrcB as unsigned; MULHU, DIVU and REMU are unsigned.
//   - Result sign fix-up is applied when registering Result on the final iteration edge.
//   - Quotient sign = signA ^ signB; remainder sign = sign of dividend.
// - Special cases (RISC-V spec, no exception):
//   - Divide by zero: DIV/DIVU -> all ones; REM/REMU -> SrcA.
//   - Signed overflow (SrcA = -2^(W-1), SrcB = -1): DIV -> -2^(W-1); REM -> 0.
//   - MUL family has no special cases.
// - Output hold: Result and out_valid stay stable while out_valid & ~out_ready (no timeout).
//   - Result keeps its last value after the handshake.
// - flush (priority below reset, above everything else):
//   - Next edge: state=IDLE, out_valid=0, iteration counter=0. Result value is don't-care.
//   - flush with in_valid in IDLE: no accept.
//   - flush in DONE with out_ready=1: the result is discarded and the transfer is not counted.
// - Counter: log2(DATA_WIDTH)+1 bits; it must not wrap before DONE.
// - Width rule: the product is computed in 2*DATA_WIDTH bits; no truncation before selecting low/high half.
//
// TESTING
// - Reset: assert rst_n=0 mid-CALC -> in_ready=1, out_valid=0, Result=0 immediately, without a clock edge.
// - MUL family: 7 MUL 6 -> 42.
//   - 0xFFFFFFFF MULHU 0xFFFFFFFF -> 0xFFFFFFFE.
//   - -1 MULH -1 -> 0.
//   - -1 MULHSU 0xFFFFFFFF -> 0xFFFFFFFF.
//   - Each with out_valid exactly 32 cycles after accept.
// - Divide, signed: -7 DIV 2 -> 0xFFFFFFFD; -7 REM 2 -> 0xFFFFFFFF.
// - Divide, unsigned: 100 DIVU 7 -> 14; 100 REMU 7 -> 2.
// - Special cases: 5 DIV 0 -> 0xFFFFFFFF; 5 REMU 0 -> 5; 0x80000000 DIV -1 -> 0x80000000; 0x80000000 REM -1 -> 0.
//   - Each with out_valid 1 cycle after accept.
// - Backpressure: hold out_ready=0 for 10 cycles after out_valid -> Result stable, in_ready=0.
//   - Raise out_ready -> IDLE next cycle; a back-to-back op is accepted the cycle after.
// - Flush: assert flush at iteration 10 of 100 DIVU 7 -> IDLE next edge, out_valid never rises.
//   - Flush with in_valid=1 -> no accept.
//   - Next op 9 REMU 4 -> 1.

Source files
------------

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative RV32M multiply/divide unit, one bit per clock
// Shift-add multiply and restoring divide share one 2W accumulator; divide specials finish in one cycle.
module mul_div_unit #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    Result
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W) + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt;
  logic [2*W-1:0]  acc;
  logic [W-1:0]    opnd;
  logic            op_div, op_sel, op_lo, res_neg;

  logic            accept, is_div, a_signed, b_signed, sign_a, sign_b;
  logic            div_zero, div_ovf, special, last;
  logic [W-1:0]    mag_a, mag_b, special_res;
  logic [W:0]      add_sum, shifted, diff;
  logic [2*W-1:0]  acc_step, prod_fix;
  logic [W-1:0]    div_val, div_fix, final_res;

  // Operand decode on the accept cycle: magnitudes, signs and divide special cases.
  always_comb begin
    is_div   = Operation[2];
    a_signed = is_div ? ~Operation[0] : (Operation[1] ^ Operation[0]);
    b_signed = is_div ? ~Operation[0] : (~Operation[1] & Operation[0]);
    sign_a   = a_signed & SrcA[W-1];
    sign_b   = b_signed & SrcB[W-1];
    mag_a    = sign_a ? -SrcA : SrcA;
    mag_b    = sign_b ? -SrcB : SrcB;
    div_zero = is_div & (SrcB == '0);
    div_ovf  = is_div & ~Operation[0] & (SrcA == {1'b1, {(W-1){1'b0}}}) & (SrcB == '1);
    special  = div_zero | div_ovf;
    if (div_zero) special_res = Operation[1] ? SrcA : '1;
    else          special_res = Operation[1] ? '0 : SrcA;
  end

  // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend/quotient}.
  always_comb begin
    add_sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : {(W+1){1'b0}});
    shifted = {acc[2*W-1:W], acc[W-1]};
    diff    = shifted - {1'b0, opnd};
    if (op_div) acc_step = diff[W] ? {shifted[W-1:0], acc[W-2:0], 1'b0}
                                   : {diff[W-1:0], acc[W-2:0], 1'b1};
    else        acc_step = {add_sum, acc[W-1:1]};
    prod_fix  = res_neg ? -acc_step : acc_step;
    div_val   = op_sel ? acc_step[2*W-1:W] : acc_step[W-1:0];
    div_fix   = res_neg ? -div_val : div_val;
    final_res = op_div ? div_fix : (op_lo ? prod_fix[W-1:0] : prod_fix[2*W-1:W]);
    last      = (cnt == CW'(W - 1));
  end

  always_comb begin
    in_ready   = (state == IDLE) & ~flush;
    out_valid  = (state == DONE) & ~flush;
    accept     = in_valid & in_ready;
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = special ? DONE : CALC;
      CALC:    if (last) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      acc     <= '0;
      opnd    <= '0;
      op_div  <= 1'b0;
      op_sel  <= 1'b0;
      op_lo   <= 1'b0;
      res_neg <= 1'b0;
      Result  <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_div  <= is_div;
          op_sel  <= Operation[1];
          op_lo   <= (Operation[1:0] == 2'b00);
          // Remainder follows the dividend sign; everything else takes signA ^ signB.
          res_neg <= (is_div & Operation[1]) ? sign_a : (sign_a ^ sign_b);
          acc     <= {{W{1'b0}}, (is_div ? mag_a : mag_b)};
          opnd    <= is_div ? mag_b : mag_a;
          cnt     <= '0;
          if (special) Result <= special_res;
        end
        CALC: begin
          acc <= acc_step;
          cnt <= cnt + CW'(1);
          if (last) begin
            Result <= final_res;
            cnt    <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - scoreboard bench for mul_div_unit
// Stimulus pushes expected result and latency; a negedge monitor pops on each output handshake.
module tb_mul_div_unit;
  localparam int W = 32;

  logic          clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [W-1:0]  src_a = '0, src_b = '0;
  logic [2:0]    op = '0;
  logic          in_ready, out_valid;
  logic [W-1:0]  result;

  mul_div_unit #(.DATA_WIDTH(W), .OPCODE_LENGTH(3)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .SrcA(src_a), .SrcB(src_b), .Operation(op), .out_valid(out_valid),
    .out_ready(out_ready), .Result(result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] exp;
    int           acc;
    int           lat;
    string        name;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Latency is counted in clock edges after the accept edge.
  logic prev_valid = 1'b0;
  int   vcyc = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !prev_valid) vcyc = cyc;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("unexpected_out_valid", 1, 0);
        else begin
          e = sb.pop_front();
          check({e.name, "_result"}, result, e.exp);
          check({e.name, "_latency"}, vcyc - e.acc, e.lat);
        end
      end
    end
    prev_valid = rst_n ? out_valid : 1'b0;
  end

  // Call at posedge+#1; returns at posedge+#1 after the accept edge with inputs scrambled.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] o,
                       input logic [W-1:0] exp, input int lat, input string name,
                       input bit push, output int acc);
    src_a = a; src_b = b; op = o; in_valid = 1'b1; acc = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = cyc + 1;
        if (push) sb.push_back('{exp, acc, lat, name});
        break;
      end
      @(posedge clk); #1;
    end
    if (acc < 0) check({name, "_accept_timeout"}, 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; src_a = $urandom; src_b = $urandom; op = 3'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  int  acc, acc2, raise_cyc;
  bit  seen;

  initial begin
    #3;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_result", result, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    issue(32'd7,        32'd6,        3'd0, 32'd42,       32, "mul",    1, acc);
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 3'd3, 32'hFFFFFFFE, 32, "mulhu",  1, acc);
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 3'd1, 32'h00000000, 32, "mulh",   1, acc);
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 3'd2, 32'hFFFFFFFF, 32, "mulhsu", 1, acc);
    issue(32'hFFFFFFF9, 32'd2,        3'd4, 32'hFFFFFFFD, 32, "div",    1, acc);
    issue(32'hFFFFFFF9, 32'd2,        3'd6, 32'hFFFFFFFF, 32, "rem",    1, acc);
    issue(32'd100,      32'd7,        3'd5, 32'd14,       32, "divu",   1, acc);
    issue(32'd100,      32'd7,        3'd7, 32'd2,        32, "remu",   1, acc);
    issue(32'd5,        32'd0,        3'd4, 32'hFFFFFFFF, 0,  "div0",   1, acc);
    issue(32'd5,        32'd0,        3'd7, 32'd5,        0,  "remu0",  1, acc);
    issue(32'h80000000, 32'hFFFFFFFF, 3'd4, 32'h80000000, 0,  "div_ovf", 1, acc);
    issue(32'h80000000, 32'hFFFFFFFF, 3'd6, 32'h00000000, 0,  "rem_ovf", 1, acc);
    drain();

    // Backpressure, then a back-to-back op accepted the cycle after the handshake.
    out_ready = 1'b0;
    issue(32'd100, 32'd7, 3'd5, 32'd14, 32, "bp_divu", 1, acc);
    for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
    check("bp_valid_wait", out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_result_hold", result, 32'd14);
      check("bp_valid_hold", out_valid, 1);
      check("bp_in_ready_low", in_ready, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    raise_cyc = cyc;
    issue(32'd100, 32'd7, 3'd7, 32'd2, 32, "b2b_remu", 1, acc2);
    check("b2b_accept_cycle", acc2, raise_cyc + 2);
    drain();

    // Flush mid-divide: back to IDLE, no result, no accept while flush is high.
    issue(32'd100, 32'd7, 3'd5, 32'd14, 32, "flush_divu", 0, acc);
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1; in_valid = 1'b1; src_a = 32'd9; src_b = 32'd4; op = 3'd7;
    @(negedge clk);
    check("flush_in_ready_calc", in_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("flush_in_ready_idle", in_ready, 0);
    check("flush_out_valid", out_valid, 0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_idle_no_accept", in_ready, 1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("flush_no_out_valid", seen, 0);
    @(posedge clk); #1;
    issue(32'd9, 32'd4, 3'd7, 32'd1, 32, "post_flush_remu", 1, acc);
    drain();

    // Asynchronous reset mid-calculation, away from any clock edge.
    issue(32'd7, 32'd6, 3'd0, 32'd42, 32, "rst_mul", 0, acc);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_in_ready", in_ready, 1);
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_result", result, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
